mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MAR/MDR register pair and memory handshake sequencer for the LC-3 datapath.
- Consumes the shared 16-bit Bus produced by the bus driver stage, which selects among MARMUX, PC, ALU and MDR.
- Feeds MDR back to that stage through MDROut.
- Runs the control FSM's MIO.EN / R.W / R memory cycle against an external memory with a req/ack handshake and a timeout.

Parameters:
- DATA_W, 16, width of Bus, MAR, MDR and memory data/address.
- TIMEOUT, 15, cycles without memAck in READ/WRITE before the access is aborted; must be 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Bus  input  DATA_W  shared datapath bus.
- ldMAR  input  1  load MAR from Bus.
- ldMDR  input  1  load MDR from Bus; honoured only when MIOEN=0.
- MIOEN  input  1  request memory access.
- RW  input  1  access type: 1=write, 0=read.
- MDROut  output  DATA_W  MDR contents, to bus driver.
- MAROut  output  DATA_W  MAR contents.
- memAddr  output  DATA_W  memory address; equals MAR.
- memWData  output  DATA_W  write data; equals MDR.
- memRData  input  DATA_W  read data from memory.
- memReq  output  1  access request, registered.
- memWe  output  1  write enable, registered, valid with memReq.
- memAck  input  1  memory completion, single-cycle pulse.
- R  output  1  ready pulse to control FSM.
- err  output  1  sticky timeout flag.
- errClr  input  1  synchronous clear of err.

Behaviour:
- Reset: rst_n low asynchronously forces the following, independent of clk:
  - MAR=0, MDR=0, state=IDLE.
  - memReq=0, memWe=0, R=0, err=0, timeout counter=0.
- Reset mid-access abandons the access; no MDR update occurs.
- FSM states:
  - IDLE: memReq=0, R=0. MIOEN=1, RW=0 -> READ. MIOEN=1, RW=1 -> WRITE. Otherwise stay.
  - READ: memReq=1, memWe=0. On memAck=1: MDR<=memRData, -> DONE.
  - WRITE: memReq=1, memWe=1. On memAck=1: -> DONE (MDR unchanged).
  - DONE: R=1 for exactly this cycle. Next state is IDLE if MIOEN=0, else HOLD.
  - HOLD: R=0. Wait for MIOEN=0, then -> IDLE. A continuously held MIOEN never starts a second access.
- Timeout: counter clears on entry to READ/WRITE and increments each cycle there without memAck. When it reaches TIMEOUT:
  - -> DONE with R=1 and err<=1.
  - MDR unchanged.
- Timeout vs ack in the same cycle: the ack wins and err is not set.
- Latency:
  - Zero-wait memory (ack in first READ/WRITE cycle): MIOEN sampled at edge N, memReq high in cycle N+1, R high in cycle N+2.
  - Each wait cycle adds 1.
- MAR:
  - ldMAR=1 in IDLE/DONE/HOLD: MAR<=Bus.
  - ldMAR ignored in READ/WRITE, so the address is stable for the whole access.
  - ldMAR and an MIOEN start in the same IDLE cycle: MAR takes the new Bus value and the access uses it (memReq only rises the following cycle).
- MDR:
  - ldMDR=1 with MIOEN=0 and state != READ: MDR<=Bus.
  - ldMDR ignored when MIOEN=1 or state=READ.
  - Memory data enters MDR only via memAck in READ.
- Stray inputs: memAck outside READ/WRITE is ignored. RW changes after the access starts are ignored; memWe is fixed at entry.
- err: stays 1 until errClr=1 (cleared next edge) or reset. A timeout and errClr in the same cycle leave err=1.
- Output registering: memAddr/MAROut and memWData/MDROut are direct register outputs, no combinational path from Bus.

Test Plan:
- Reset: rst_n=0 mid-READ (memReq=1) -> memReq=0, MDROut=0x0000, R=0 immediately without a clock edge; after release, state IDLE.
- Zero-wait read: Bus=0x3000, ldMAR, then MIOEN=1, RW=0; memAck with memRData=0xBEEF in first READ cycle -> memAddr=0x3000, MDROut=0xBEEF, R=1 exactly one cycle, 2 cycles after MIOEN sample.
- Wait-state write: MDR loaded 0x1234 from Bus, MAR=0xFE06, MIOEN=1, RW=1, ack after 3 wait cycles -> memWe=1, memWData=0x1234 for 4 cycles; R after 5; ldMAR with Bus=0x0000 during access leaves memAddr=0xFE06.
- Timeout: TIMEOUT=15, read, never ack -> R=1 after 15 READ cycles, err=1, MDR unchanged; errClr pulse -> err=0 next cycle.
- Held MIOEN: MIOEN kept 1 for 10 cycles after R -> exactly one memReq period, state HOLD; drop MIOEN -> IDLE, new request accepted.
- MDR priority: ldMDR=1, MIOEN=1, RW=0, Bus=0xAAAA -> MDR not loaded from Bus; final MDR=memRData=0x5555.

Source files
------------

// File: rtl/mem_access_unit.sv
// MAR/MDR register pair plus the memory req/ack sequencer for the LC-3 datapath.
// One access per MIOEN assertion; a stalled memory is abandoned after TIMEOUT cycles.
module mem_access_unit #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] Bus,
   input  logic              ldMAR,
   input  logic              ldMDR,
   input  logic              MIOEN,
   input  logic              RW,
   output logic [DATA_W-1:0] MDROut,
   output logic [DATA_W-1:0] MAROut,
   output logic [DATA_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   output logic              memReq,
   output logic              memWe,
   input  logic              memAck,
   output logic              R,
   output logic              err,
   input  logic              errClr
);

   typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, HOLD} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t              state_q;
   logic [DATA_W-1:0]   mar_q;
   logic [DATA_W-1:0]   mdr_q;
   logic [7:0]          cnt_q;
   logic                req_q;
   logic                we_q;
   logic                r_q;
   logic                err_q;
   logic                busy;
   logic                expire;

   assign busy   = (state_q == READ) || (state_q == WRITE);
   // An ack in the final allowed cycle still completes the access cleanly.
   assign expire = busy && !memAck && (cnt_q == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         r_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         r_q <= 1'b0;
         if (ldMAR && !busy)
            mar_q <= Bus;
         if (ldMDR && !MIOEN && (state_q != READ))
            mdr_q <= Bus;
         if (errClr)
            err_q <= 1'b0;
         if (expire)
            err_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (MIOEN) begin
                  state_q <= RW ? WRITE : READ;
                  req_q   <= 1'b1;
                  we_q    <= RW;
                  cnt_q   <= '0;
               end
            end
            READ, WRITE: begin
               if (memAck || expire) begin
                  if (memAck && (state_q == READ))
                     mdr_q <= memRData;
                  state_q <= DONE;
                  req_q   <= 1'b0;
                  we_q    <= 1'b0;
                  r_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: state_q <= MIOEN ? HOLD : IDLE;
            HOLD: begin
               if (!MIOEN)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MAROut   = mar_q;
   assign memAddr  = mar_q;
   assign MDROut   = mdr_q;
   assign memWData = mdr_q;
   assign memReq   = req_q;
   assign memWe    = we_q;
   assign R        = r_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: expected access results are queued at
// request time and retired when the unit raises R.
module tb_mem_access_unit;

   localparam int DW      = 16;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] Bus;
   logic          ldMAR, ldMDR, MIOEN, RW;
   logic [DW-1:0] MDROut, MAROut, memAddr, memWData, memRData;
   logic          memReq, memWe, memAck, R, err, errClr;

   typedef struct {
      logic [DW-1:0] mdr;
      logic          err;
      int            reqs;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_access_unit #(.DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .Bus(Bus), .ldMAR(ldMAR), .ldMDR(ldMDR),
      .MIOEN(MIOEN), .RW(RW), .MDROut(MDROut), .MAROut(MAROut),
      .memAddr(memAddr), .memWData(memWData), .memRData(memRData),
      .memReq(memReq), .memWe(memWe), .memAck(memAck), .R(R), .err(err),
      .errClr(errClr)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one access from IDLE; leaves the bench in the DONE cycle with MIOEN still high.
   task automatic access(input logic rw, input int waits, input logic give_ack,
                         input logic [DW-1:0] rdata, input logic [DW-1:0] exp_mdr,
                         input logic exp_err, input logic [DW-1:0] exp_addr,
                         input logic hold_clr, input logic ld_at_start);
      exp_t e;
      int   reqs;
      logic done;
      logic [DW-1:0] wdata_at_start;
      e.mdr  = exp_mdr;
      e.err  = exp_err;
      e.reqs = give_ack ? waits + 1 : TIMEOUT;
      sb.push_back(e);
      wdata_at_start = memWData;
      MIOEN  = 1'b1;
      RW     = rw;
      errClr = hold_clr;
      if (ld_at_start) begin
         ldMDR = 1'b1;
         Bus   = 16'hAAAA;
      end
      tick();
      ldMDR = 1'b0;
      ldMAR = 1'b1;
      Bus   = 16'h0000;
      RW    = ~rw;
      reqs  = 0;
      done  = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         if (memReq) reqs++;
         check_val("addr_stable", memAddr, exp_addr);
         check_val("we_fixed", memWe, rw);
         if (rw) check_val("wdata", memWData, wdata_at_start);
         if (give_ack && c == waits) begin
            memAck   = 1'b1;
            memRData = rdata;
         end
         tick();
         memAck   = 1'b0;
         memRData = 16'h0000;
         if (R) done = 1'b1;
      end
      ldMAR  = 1'b0;
      errClr = 1'b0;
      check_val("done_seen", done, 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_val("mdr_result", MDROut, e.mdr);
         check_val("err_result", err, e.err);
         check_val("req_cycles", reqs, e.reqs);
      end
      check_val("req_off_done", memReq, 1'b0);
   endtask

   task automatic finish_idle();
      MIOEN = 1'b0;
      tick();
      check_val("r_one_cycle", R, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; Bus = '0; ldMAR = 0; ldMDR = 0; MIOEN = 0; RW = 0;
      memRData = '0; memAck = 0; errClr = 0;
      #3;
      check_val("rst_req", memReq, 1'b0);
      check_val("rst_mar", MAROut, 16'h0000);
      check_val("rst_mdr", MDROut, 16'h0000);
      check_val("rst_r", R, 1'b0);
      check_val("rst_err", err, 1'b0);
      #20 rst_n = 1'b1;
      tick();

      // Zero-wait read
      Bus = 16'h3000; ldMAR = 1'b1;
      tick();
      ldMAR = 1'b0;
      access(1'b0, 0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 16'h3000, 1'b0, 1'b0);
      finish_idle();

      // Asynchronous reset in the middle of a read
      MIOEN = 1'b1; RW = 1'b0;
      tick();
      check_val("pre_rst_req", memReq, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_req", memReq, 1'b0);
      check_val("async_mdr", MDROut, 16'h0000);
      check_val("async_r", R, 1'b0);
      rst_n = 1'b1; MIOEN = 1'b0;
      tick();
      check_val("post_rst_idle", memReq, 1'b0);

      // Stray ack in IDLE must not touch MDR
      memAck = 1'b1; memRData = 16'h7777;
      tick();
      memAck = 1'b0; memRData = 16'h0000;
      check_val("stray_ack_mdr", MDROut, 16'h0000);
      check_val("stray_ack_r", R, 1'b0);

      // Write with three wait states, address overwrite attempts during the access
      Bus = 16'h1234; ldMDR = 1'b1;
      tick();
      ldMDR = 1'b0; Bus = 16'hFE06; ldMAR = 1'b1;
      tick();
      ldMAR = 1'b0;
      check_val("wdata_loaded", memWData, 16'h1234);
      access(1'b1, 3, 1'b1, 16'hDEAD, 16'h1234, 1'b0, 16'hFE06, 1'b0, 1'b0);
      finish_idle();

      // Timeout on a read, then errClr
      access(1'b0, 0, 1'b0, 16'h0000, 16'h1234, 1'b1, 16'hFE06, 1'b0, 1'b0);
      finish_idle();
      check_val("err_sticky", err, 1'b1);
      errClr = 1'b1;
      tick();
      errClr = 1'b0;
      check_val("err_cleared", err, 1'b0);

      // Timeout while errClr is held: set wins
      access(1'b0, 0, 1'b0, 16'h0000, 16'h1234, 1'b1, 16'hFE06, 1'b1, 1'b0);
      finish_idle();
      errClr = 1'b1;
      tick();
      errClr = 1'b0;

      // Ack in the final allowed cycle beats the timeout
      access(1'b0, TIMEOUT - 1, 1'b1, 16'h4242, 16'h4242, 1'b0, 16'hFE06, 1'b0, 1'b0);

      // MIOEN held after completion: no second access
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("hold_no_req", memReq, 1'b0);
         check_val("hold_no_r", R, 1'b0);
      end
      MIOEN = 1'b0;
      tick();

      // ldMDR together with a read start is ignored; memory data wins
      access(1'b0, 1, 1'b1, 16'h5555, 16'h5555, 1'b0, 16'hFE06, 1'b0, 1'b1);
      finish_idle();
      check_val("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
